eth_frame_capture: RTL
======================

Name: eth_frame_capture

Overview:
Parametrised MII frame capture engine, the successor to the ad-hoc receive/RAM logic in the top level. It takes a nibble stream already synchronised into the mainclk domain and strips preamble/SFD. It assembles bytes in correct nibble order, packs them little-endian into WORD_W words, and stores one frame in an internal buffer. The stored frame is replayed on a valid/ready word stream, which feeds the UART hex dumper or the I2S playback path.

Parameters:
WORD_W, 32, output/storage word width in bits; multiple of 8, minimum 8.
DEPTH, 512, buffer depth in words; power of two, minimum 2.
MAX_BYTES, DEPTH*WORD_W/8, derived capacity in bytes; not overridable.

Ports:
mainclk  in  1  clock.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  one-cycle strobe: in_nibble/in_dv/in_err are valid this cycle.
in_nibble  in  4  MII nibble (bit 0 = rxd[0]).
in_dv  in  1  MII data valid, sampled with in_valid.
in_err  in  1  MII receive error, sampled with in_valid.
arm  in  1  pulse: start hunting for the next frame.
auto_rearm  in  1  1 = return to ARMED after readout; 0 = return to IDLE.
rd_start  in  1  pulse: begin readout of the stored frame.
out_valid  out  1  output word valid.
out_data  out  WORD_W  output word.
out_last  out  1  marks the final word of the frame.
out_ready  in  1  consumer accepts the word when out_valid & out_ready.
frame_len  out  $clog2(MAX_BYTES+1)  stored byte count.
busy  out  1  state != IDLE.
frame_ready  out  1  state == HOLD.
overflow  out  1  sticky per frame: frame exceeded MAX_BYTES.
err_seen  out  1  sticky per frame: in_err seen, or odd nibble count at end of frame.

Behaviour:
- Reset values: all outputs 0, state IDLE, write pointer 0, read pointer 0.
- States and transitions:
  - IDLE: arm -> ARMED. In any other state, arm is ignored.
  - ARMED: wait for an in_valid cycle with in_dv=0, then -> HUNT. This prevents capturing a frame that is already in progress.
  - HUNT: on an in_valid cycle with in_dv=1, match the preamble. SFD is detected when nibble 0xD arrives immediately after at least one 0x5 nibble; go to CAPTURE. Any other nibble resets the match. If in_dv drops before SFD, stay in HUNT.
  - CAPTURE: see byte/word assembly and end-of-frame rules below.
  - HOLD: frame stored; frame_ready=1. rd_start -> READOUT.
  - READOUT: see readout rules below.
- Entering CAPTURE clears frame_len, overflow, err_seen and the write pointer.
- Byte assembly: the first nibble of a pair is bits [3:0], the second is bits [7:4]. Byte k of a word occupies bits [8k+7:8k].
- Word write: a word is written to RAM when its last byte completes. frame_len increments once per byte.
- End of frame: the first in_valid cycle with in_dv=0 in CAPTURE.
  - A pending partial word is written zero-padded in its upper bytes.
  - A dangling single nibble is dropped and sets err_seen.
  - Then -> HOLD.
- Errors: in_err=1 on any CAPTURE nibble sets err_seen. Capture continues.
- Overflow: once frame_len == MAX_BYTES, further bytes set overflow and are discarded. frame_len saturates; the frame still ends normally.
- Empty frame (in_dv drops right after SFD): -> HOLD with frame_len=0. rd_start then returns immediately to IDLE/ARMED with no out_valid.
- Readout:
  - Words are read 0..ceil(frame_len*8/WORD_W)-1. RAM read latency is 1 cycle.
  - A one-entry prefetch register holds out_data stable while out_valid & ~out_ready.
  - First out_valid appears no later than 2 cycles after rd_start; with out_ready held high, one word is delivered per cycle.
  - out_last=1 on the final word only.
  - After the final handshake: auto_rearm ? ARMED : IDLE. The stored data and frame_len remain readable only until the next CAPTURE.
- Simultaneous events: rst dominates everything. arm coincident with rd_start in HOLD: rd_start wins and arm is ignored.
- Reset mid-operation: any state returns to IDLE next cycle, and out_valid deasserts the same edge. RAM contents need not be cleared.

Decomposition:
- Package eth_capture_pkg:
  - state enum (IDLE, ARMED, HUNT, CAPTURE, HOLD, READOUT);
  - constants PREAMBLE_NIB=4'h5, SFD_NIB=4'hD.
- Sub-module capture_ram: simple dual-port with synchronous read, parameters WIDTH/DEPTH, 1-cycle read latency. Inferable as block RAM.

Test Plan:
All scenarios use WORD_W=32, DEPTH=16 (MAX_BYTES=64).
1. 15 nibbles of 0x5, then 0xD, then bytes 01..08 sent low nibble first, then in_dv=0 -> frame_len=8; words 0x04030201, 0x08070605; out_last on the 2nd word; err_seen=0.
2. 5-byte frame 11 22 33 44 55 -> frame_len=5; words 0x44332211, 0x00000055 (out_last=1).
3. 70-byte frame -> overflow=1, frame_len=64, exactly 16 words read, the last holding bytes 61..64.
4. Frame 1 with out_ready toggling 1,0,0,1,... -> out_data/out_last stable while stalled; no words dropped or duplicated.
5. Assert arm while in_dv=1 mid-frame -> that frame is ignored and the next frame is captured. With auto_rearm=1, state returns to ARMED after readout; odd nibble count sets err_seen.
6. rst asserted in CAPTURE after 3 bytes -> next cycle busy=0, out_valid=0, frame_len=0. A subsequent arm plus scenario-1 frame reads back correctly.

Source files
------------

// File: rtl/eth_capture_pkg.sv
// Shared types and constants for the MII frame capture engine.
package eth_capture_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        HUNT    = 3'd2,
        CAPTURE = 3'd3,
        HOLD    = 3'd4,
        READOUT = 3'd5
    } cap_state_e;

    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hD;

endpackage : eth_capture_pkg

// File: rtl/eth_frame_capture_ram.sv
// Simple dual-port frame buffer with a registered (1-cycle) read port.
module capture_ram
    import eth_capture_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 512,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             mainclk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port.
    always_ff @(posedge mainclk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port; output holds its value while re_i is low.
    always_ff @(posedge mainclk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : capture_ram

// File: rtl/eth_frame_capture.sv
// MII frame capture: strips preamble/SFD, packs bytes little-endian into
// words, buffers one frame and replays it on a valid/ready word stream.
module eth_frame_capture
    import eth_capture_pkg::*;
#(
    parameter  int unsigned WORD_W    = 32,
    parameter  int unsigned DEPTH     = 512,
    localparam int unsigned MAX_BYTES = DEPTH * WORD_W / 8,
    localparam int unsigned LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic              mainclk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [3:0]        in_nibble_i,
    input  logic              in_dv_i,
    input  logic              in_err_i,
    input  logic              arm_i,
    input  logic              auto_rearm_i,
    input  logic              rd_start_i,
    output logic              out_valid_o,
    output logic [WORD_W-1:0] out_data_o,
    output logic              out_last_o,
    input  logic              out_ready_i,
    output logic [LEN_W-1:0]  frame_len_o,
    output logic              busy_o,
    output logic              frame_ready_o,
    output logic              overflow_o,
    output logic              err_seen_o
);

    localparam int unsigned BPW    = WORD_W / 8;
    localparam int unsigned BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PW     = AW + 1;

    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BPW - 1);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_BYTES);

    cap_state_e         state_q;
    logic               pre_seen_q;
    logic [3:0]         nib_lo_q;
    logic               nib_half_q;
    logic [WORD_W-1:0]  word_q;
    logic [BIDX_W-1:0]  byte_idx_q;
    logic [AW-1:0]      wr_ptr_q;
    logic [LEN_W-1:0]   frame_len_q;
    logic               overflow_q;
    logic               err_q;
    logic [PW-1:0]      rd_ptr_q;
    logic               a_vld_q;
    logic               a_last_q;
    logic               out_valid_q;
    logic [WORD_W-1:0]  out_data_q;
    logic               out_last_q;

    logic [7:0]         cap_byte_c;
    logic               byte_ok_c;
    logic               eof_c;
    logic [WORD_W-1:0]  word_ins_c;
    logic               ram_we_c;
    logic [WORD_W-1:0]  ram_wdata_c;
    logic [PW-1:0]      nwords_c;
    logic               take_c;
    logic               move_c;
    logic               start_rd_c;
    logic               issue_c;
    logic [PW-1:0]      issue_addr_c;
    logic               issue_last_c;
    logic [WORD_W-1:0]  ram_rdata;

    // Capture datapath: byte assembly and RAM write decision.
    always_comb begin
        cap_byte_c = {in_nibble_i, nib_lo_q};
        byte_ok_c  = (state_q == CAPTURE) && in_valid_i && in_dv_i && nib_half_q
                     && (frame_len_q != LEN_MAX);
        eof_c      = (state_q == CAPTURE) && in_valid_i && !in_dv_i;
        word_ins_c = word_q;
        for (int unsigned k = 0; k < BPW; k++) begin
            if (byte_idx_q == BIDX_W'(k)) begin
                word_ins_c[8*k +: 8] = cap_byte_c;
            end
        end
        ram_we_c    = (byte_ok_c && (byte_idx_q == BIDX_LAST))
                      || (eof_c && (byte_idx_q != '0));
        ram_wdata_c = byte_ok_c ? word_ins_c : word_q;
    end

    // Readout datapath: RAM output acts as a second pipeline slot ahead of out_data.
    always_comb begin
        nwords_c     = PW'((32'(frame_len_q) + BPW - 1) / BPW);
        take_c       = out_valid_q && out_ready_i;
        move_c       = a_vld_q && (!out_valid_q || take_c);
        start_rd_c   = (state_q == HOLD) && rd_start_i && (nwords_c != '0);
        issue_c      = start_rd_c
                       || ((state_q == READOUT) && (rd_ptr_q < nwords_c)
                           && (!a_vld_q || move_c));
        issue_addr_c = start_rd_c ? '0 : rd_ptr_q;
        issue_last_c = (issue_addr_c == (nwords_c - PW'(1)));
    end

    // Control FSM with capture and readout registers.
    always_ff @(posedge mainclk) begin
        if (rst) begin
            state_q     <= IDLE;
            pre_seen_q  <= 1'b0;
            nib_lo_q    <= '0;
            nib_half_q  <= 1'b0;
            word_q      <= '0;
            byte_idx_q  <= '0;
            wr_ptr_q    <= '0;
            frame_len_q <= '0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
            rd_ptr_q    <= '0;
            a_vld_q     <= 1'b0;
            a_last_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (issue_c) begin
                rd_ptr_q <= issue_addr_c + PW'(1);
                a_vld_q  <= 1'b1;
                a_last_q <= issue_last_c;
            end else if (move_c) begin
                a_vld_q  <= 1'b0;
            end

            if (move_c) begin
                out_valid_q <= 1'b1;
                out_data_q  <= ram_rdata;
                out_last_q  <= a_last_q;
            end else if (take_c) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (arm_i) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (in_valid_i && !in_dv_i) begin
                        state_q    <= HUNT;
                        pre_seen_q <= 1'b0;
                    end
                end
                HUNT: begin
                    if (in_valid_i) begin
                        if (!in_dv_i) begin
                            pre_seen_q <= 1'b0;
                        end else if ((in_nibble_i == SFD_NIB) && pre_seen_q) begin
                            state_q     <= CAPTURE;
                            pre_seen_q  <= 1'b0;
                            nib_half_q  <= 1'b0;
                            word_q      <= '0;
                            byte_idx_q  <= '0;
                            wr_ptr_q    <= '0;
                            frame_len_q <= '0;
                            overflow_q  <= 1'b0;
                            err_q       <= 1'b0;
                        end else begin
                            pre_seen_q <= (in_nibble_i == PREAMBLE_NIB);
                        end
                    end
                end
                CAPTURE: begin
                    if (in_valid_i && in_dv_i) begin
                        if (in_err_i) begin
                            err_q <= 1'b1;
                        end
                        if (!nib_half_q) begin
                            nib_lo_q   <= in_nibble_i;
                            nib_half_q <= 1'b1;
                        end else begin
                            nib_half_q <= 1'b0;
                            if (frame_len_q == LEN_MAX) begin
                                overflow_q <= 1'b1;
                            end else begin
                                frame_len_q <= frame_len_q + LEN_W'(1);
                                if (byte_idx_q == BIDX_LAST) begin
                                    word_q     <= '0;
                                    byte_idx_q <= '0;
                                    wr_ptr_q   <= wr_ptr_q + AW'(1);
                                end else begin
                                    word_q     <= word_ins_c;
                                    byte_idx_q <= byte_idx_q + BIDX_W'(1);
                                end
                            end
                        end
                    end else if (in_valid_i) begin
                        // A lone trailing nibble cannot form a byte; drop and flag it.
                        if (nib_half_q) begin
                            err_q <= 1'b1;
                        end
                        nib_half_q <= 1'b0;
                        word_q     <= '0;
                        byte_idx_q <= '0;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (rd_start_i) begin
                        if (nwords_c == '0) begin
                            state_q <= auto_rearm_i ? ARMED : IDLE;
                        end else begin
                            state_q <= READOUT;
                        end
                    end
                end
                READOUT: begin
                    if (take_c && out_last_q) begin
                        state_q <= auto_rearm_i ? ARMED : IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    capture_ram #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .mainclk (mainclk),
        .we_i    (ram_we_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (ram_wdata_c),
        .re_i    (issue_c),
        .raddr_i (issue_addr_c[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign out_last_o    = out_last_q;
    assign frame_len_o   = frame_len_q;
    assign overflow_o    = overflow_q;
    assign err_seen_o    = err_q;
    assign busy_o        = (state_q != IDLE);
    assign frame_ready_o = (state_q == HOLD);

endmodule : eth_frame_capture
